// File: rtl/rom_fetch_unit_if.sv
// Bus bundle between the fetch unit, the program ROM and the instruction decoder.
// The master modport is the fetch unit. The slave modport is the ROM plus decoder side.
interface rom_fetch_unit_if;
  // ROM read port
  logic [7:0]  rom_addr;
  logic        rom_cs;
  logic        rom_oe;
  logic [15:0] rom_data;

  // Decoder-facing instruction stream
  logic [15:0] instr;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  // Control from the decoder or sequencer
  logic        jump;
  logic [7:0]  jump_addr;
  logic        fetch_en;

  modport master (
    output rom_addr, rom_cs, rom_oe,
    input  rom_data,
    output instr, instr_addr, instr_valid,
    input  instr_ready,
    input  jump, jump_addr, fetch_en
  );

  modport slave (
    input  rom_addr, rom_cs, rom_oe,
    output rom_data,
    input  instr, instr_addr, instr_valid,
    output instr_ready,
    output jump, jump_addr, fetch_en
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// Read-side initiator for the 256x16 program ROM.
// The unit issues one read at a time and captures each word RD_LAT posedges after
// the issue cycle. Each captured word is queued with its address in a 2-entry
// first-word-first prefetch buffer, which the decoder drains through valid/ready.
// A jump flushes everything, including an in-flight read, and redirects fetch.
module rom_fetch_unit #(
  parameter int          RD_LAT     = 2,     // 1..7
  parameter logic [7:0]  RESET_PC   = 8'd1,
  parameter int          FIFO_DEPTH = 2      // fixed at 2
) (
  input  logic            clk,
  input  logic            rst,
  rom_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } entry_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  localparam logic [1:0] DEPTH  = 2'(FIFO_DEPTH);

  // Fetch state machine registers
  state_t      r_state;
  logic [7:0]  r_pc;
  logic [7:0]  r_tag;
  logic [2:0]  r_cnt;
  logic [7:0]  r_rom_addr;
  logic        r_rom_cs;
  logic        r_rom_oe;

  // Prefetch buffer registers
  entry_t      r_mem [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_occ_after_pop;
  logic        w_space;
  entry_t      w_head;

  assign w_pop  = (r_count != 2'd0) && bus.instr_ready;
  assign w_push = (r_state == S_WAIT) && (r_cnt == 3'd0);

  // A new read is only started from IDLE, where nothing is in flight, so the
  // occupancy check reduces to buffer entries. An entry the decoder takes this
  // cycle already counts as free space.
  assign w_occ_after_pop = r_count - {1'b0, w_pop};
  assign w_space         = (w_occ_after_pop < DEPTH);

  assign w_head = r_mem[r_rd_ptr];

  assign bus.rom_addr    = r_rom_addr;
  assign bus.rom_cs      = r_rom_cs;
  assign bus.rom_oe      = r_rom_oe;
  assign bus.instr       = w_head.data;
  assign bus.instr_addr  = w_head.addr;
  assign bus.instr_valid = (r_count != 2'd0);

  // Fetch FSM: issue one read, count down the ROM latency, then return to IDLE.
  // A jump takes priority over everything except reset.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values.
    // Blocking assignments would let later statements observe half-updated state.
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_tag      <= 8'd0;
      r_cnt      <= 3'd0;
      r_rom_addr <= 8'd0;
      r_rom_cs   <= 1'b0;
      r_rom_oe   <= 1'b0;
    end else if (bus.jump) begin
      r_state  <= S_IDLE;
      r_pc     <= bus.jump_addr;
      r_cnt    <= 3'd0;
      r_rom_cs <= 1'b0;
      r_rom_oe <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.fetch_en && w_space) begin
            r_state    <= S_ISSUE;
            r_rom_addr <= r_pc;
            r_rom_cs   <= 1'b1;
            r_rom_oe   <= 1'b1;
            r_tag      <= r_pc;
          end
        end
        S_ISSUE: begin
          r_rom_cs <= 1'b0;
          r_rom_oe <= 1'b0;
          r_cnt    <= LAT_M1;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_pc    <= r_tag + 8'd1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Prefetch buffer: push the captured word, pop on handshake, flush on jump.
  always_ff @(posedge clk) begin
    // NOTE: the two storage slots are reset because the head slot drives
    // instr/instr_addr directly, and those outputs must read 0 out of reset.
    if (rst) begin
      r_mem    <= '{default: '0};
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (bus.jump) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{addr: r_tag, data: bus.rom_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit. The main instance is built with RD_LAT=2.
// Two extra instances with RD_LAT=1 and RD_LAT=7 are used for the latency sweep.
// Each instance gets its own synchronous ROM model.
module tb_rom_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  // Posedge counter used to measure issue-to-sample distance
  always @(posedge clk) cyc <= cyc + 1;

  rom_fetch_unit_if bus2 ();
  rom_fetch_unit_if bus1 ();
  rom_fetch_unit_if bus7 ();

  rom_fetch_unit #(.RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  rom_fetch_unit #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  rom_fetch_unit #(.RD_LAT(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

  // ROM contents: word 1 is 16'h007F, addresses 0 and >137 read 16'hFFFF
  function automatic logic [15:0] rom_word(input logic [7:0] a);
    if (a == 8'd1) return 16'h007F;
    if (a == 8'd0 || a > 8'd137) return 16'hFFFF;
    return {a ^ 8'h5A, a};
  endfunction

  // ROM models: CS/OE are sampled at a posedge, and data is valid only in the
  // cycle ending RD_LAT posedges later. Outside that cycle they drive 16'hDEAD.
  logic [7:0][16:0] pipe2 = '0;
  logic [7:0][16:0] pipe1 = '0;
  logic [7:0][16:0] pipe7 = '0;

  always @(posedge clk) begin
    pipe2 <= {pipe2[6:0], (bus2.rom_cs && bus2.rom_oe) ? {1'b1, rom_word(bus2.rom_addr)} : 17'h0};
    pipe1 <= {pipe1[6:0], (bus1.rom_cs && bus1.rom_oe) ? {1'b1, rom_word(bus1.rom_addr)} : 17'h0};
    pipe7 <= {pipe7[6:0], (bus7.rom_cs && bus7.rom_oe) ? {1'b1, rom_word(bus7.rom_addr)} : 17'h0};
  end

  assign bus2.rom_data = pipe2[1][16] ? pipe2[1][15:0] : 16'hDEAD;
  assign bus1.rom_data = pipe1[0][16] ? pipe1[0][15:0] : 16'hDEAD;
  assign bus7.rom_data = pipe7[6][16] ? pipe7[6][15:0] : 16'hDEAD;

  // Monitor mux used by the latency sweep (sel 1 or 7)
  int          mon_sel = 1;
  logic        m_cs, m_valid;
  logic [7:0]  m_addr, m_iaddr;
  logic [15:0] m_instr;
  assign m_cs    = (mon_sel == 7) ? bus7.rom_cs      : bus1.rom_cs;
  assign m_valid = (mon_sel == 7) ? bus7.instr_valid : bus1.instr_valid;
  assign m_addr  = (mon_sel == 7) ? bus7.rom_addr    : bus1.rom_addr;
  assign m_iaddr = (mon_sel == 7) ? bus7.instr_addr  : bus1.instr_addr;
  assign m_instr = (mon_sel == 7) ? bus7.instr       : bus1.instr;

  // Holds rst for two posedges and releases it at a negedge.
  // The next posedge (E0) is the first one in which the DUT runs.
  task automatic do_reset();
    rst = 1'b1;
    bus2.jump = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus2.instr_ready = 1'b1;
    bus2.fetch_en    = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus2.rom_cs !== 1'b0) begin n_fails++; $display("FAIL reset_cs: got %b want 0", bus2.rom_cs); end
    n_checks++; if (bus2.rom_oe !== 1'b0) begin n_fails++; $display("FAIL reset_oe: got %b want 0", bus2.rom_oe); end
    n_checks++; if (bus2.rom_addr !== 8'd0) begin n_fails++; $display("FAIL reset_rom_addr: got %h want 00", bus2.rom_addr); end
    n_checks++; if (bus2.instr !== 16'd0) begin n_fails++; $display("FAIL reset_instr: got %h want 0000", bus2.instr); end
    n_checks++; if (bus2.instr_addr !== 8'd0) begin n_fails++; $display("FAIL reset_instr_addr: got %h want 00", bus2.instr_addr); end
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", bus2.instr_valid); end
    rst = 1'b0;
    @(negedge clk);  // after E0: issue cycle
    n_checks++; if ({bus2.rom_cs, bus2.rom_oe, bus2.rom_addr} !== {1'b1, 1'b1, 8'd1}) begin n_fails++; $display("FAIL first_issue: got cs=%b oe=%b addr=%h want cs=1 oe=1 addr=01", bus2.rom_cs, bus2.rom_oe, bus2.rom_addr); end
    @(negedge clk);  // after E1: waiting
    n_checks++; if ({bus2.rom_cs, bus2.rom_oe, bus2.rom_addr} !== {1'b0, 1'b0, 8'd1}) begin n_fails++; $display("FAIL wait_outputs: got cs=%b oe=%b addr=%h want cs=0 oe=0 addr=01", bus2.rom_cs, bus2.rom_oe, bus2.rom_addr); end
    @(negedge clk);  // after E2
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL early_valid: got %b want 0", bus2.instr_valid); end
    @(negedge clk);  // after E3: word visible
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd1, 16'h007F}) begin n_fails++; $display("FAIL first_word: got v=%b a=%h d=%h want v=1 a=01 d=007f", bus2.instr_valid, bus2.instr_addr, bus2.instr); end
    @(negedge clk);  // after E4: popped, next issue
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd2}) begin n_fails++; $display("FAIL second_issue: got cs=%b addr=%h want cs=1 addr=02", bus2.rom_cs, bus2.rom_addr); end
  endtask

  task automatic test_backpressure();
    int n_cs;
    logic [7:0] a0, a1;
    n_cs = 0; a0 = 8'hXX; a1 = 8'hXX;
    bus2.instr_ready = 1'b0;
    bus2.fetch_en    = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.rom_cs) begin
        if (n_cs == 0) a0 = bus2.rom_addr;
        if (n_cs == 1) a1 = bus2.rom_addr;
        n_cs++;
      end
    end
    n_checks++; if (n_cs != 2) begin n_fails++; $display("FAIL bp_issue_count: got %0d want 2", n_cs); end
    n_checks++; if ({a0, a1} !== {8'd1, 8'd2}) begin n_fails++; $display("FAIL bp_issue_addrs: got %h,%h want 01,02", a0, a1); end
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd1, 16'h007F}) begin n_fails++; $display("FAIL bp_head: got v=%b a=%h d=%h want v=1 a=01 d=007f", bus2.instr_valid, bus2.instr_addr, bus2.instr); end
    bus2.instr_ready = 1'b1;
    @(negedge clk);  // first pop done, addr 3 issued
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd2, rom_word(8'd2)}) begin n_fails++; $display("FAIL bp_second_head: got v=%b a=%h d=%h want v=1 a=02 d=%h", bus2.instr_valid, bus2.instr_addr, bus2.instr, rom_word(8'd2)); end
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd3}) begin n_fails++; $display("FAIL bp_resume_issue: got cs=%b addr=%h want cs=1 addr=03", bus2.rom_cs, bus2.rom_addr); end
    @(negedge clk);  // second pop done
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL bp_drained: got valid=%b want 0", bus2.instr_valid); end
    bus2.instr_ready = 1'b0;
    repeat (5) @(negedge clk);  // addr 3 buffered, addr 4 in flight
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr} !== {1'b1, 8'd3}) begin n_fails++; $display("FAIL bp_addr3: got v=%b a=%h want v=1 a=03", bus2.instr_valid, bus2.instr_addr); end
    bus2.instr_ready = 1'b1;  // pop addr 3 on the same edge that pushes addr 4
    @(negedge clk);
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd4, rom_word(8'd4)}) begin n_fails++; $display("FAIL push_pop_same_cycle: got v=%b a=%h d=%h want v=1 a=04 d=%h", bus2.instr_valid, bus2.instr_addr, bus2.instr, rom_word(8'd4)); end
    bus2.instr_ready = 1'b0;
  endtask

  task automatic test_jump();
    bus2.instr_ready = 1'b0;
    bus2.fetch_en    = 1'b1;
    do_reset();
    bus2.jump = 1'b1; bus2.jump_addr = 8'd4;
    @(negedge clk);  // E0 took the jump instead of issuing
    bus2.jump = 1'b0;
    n_checks++; if (bus2.rom_cs !== 1'b0) begin n_fails++; $display("FAIL jump_blocks_issue: got cs=%b want 0", bus2.rom_cs); end
    @(negedge clk);  // E1
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd4}) begin n_fails++; $display("FAIL jump_target_issue: got cs=%b addr=%h want cs=1 addr=04", bus2.rom_cs, bus2.rom_addr); end
    repeat (5) @(negedge clk);  // E6: waiting for addr 5, addr 4 buffered
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd4, 1'b0, 8'd5}) begin n_fails++; $display("FAIL pre_jump_state: got v=%b a=%h cs=%b rom_addr=%h want v=1 a=04 cs=0 rom_addr=05", bus2.instr_valid, bus2.instr_addr, bus2.rom_cs, bus2.rom_addr); end
    bus2.jump = 1'b1; bus2.jump_addr = 8'd100;
    @(negedge clk);  // E7
    bus2.jump = 1'b0;
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL jump_flush: got valid=%b want 0", bus2.instr_valid); end
    @(negedge clk);  // E8: addr 5 sample edge passed with no push
    n_checks++; if ({bus2.instr_valid, bus2.rom_cs, bus2.rom_addr} !== {1'b0, 1'b1, 8'd100}) begin n_fails++; $display("FAIL jump_redirect: got v=%b cs=%b addr=%0d want v=0 cs=1 addr=100", bus2.instr_valid, bus2.rom_cs, bus2.rom_addr); end
    repeat (2) @(negedge clk);  // E10: next posedge samples addr 100 data
    bus2.jump = 1'b1; bus2.jump_addr = 8'd50;
    @(negedge clk);  // E11
    bus2.jump = 1'b0;
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL jump_at_sample: got valid=%b want 0", bus2.instr_valid); end
    @(negedge clk);  // E12
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd50}) begin n_fails++; $display("FAIL jump2_redirect: got cs=%b addr=%0d want cs=1 addr=50", bus2.rom_cs, bus2.rom_addr); end
    repeat (3) @(negedge clk);  // E15
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd50, rom_word(8'd50)}) begin n_fails++; $display("FAIL jump2_word: got v=%b a=%h d=%h want v=1 a=32 d=%h", bus2.instr_valid, bus2.instr_addr, bus2.instr, rom_word(8'd50)); end
  endtask

  task automatic test_wrap();
    bus2.instr_ready = 1'b1;
    bus2.fetch_en    = 1'b1;
    do_reset();
    bus2.jump = 1'b1; bus2.jump_addr = 8'd255;
    @(negedge clk);
    bus2.jump = 1'b0;
    @(negedge clk);  // E1
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd255}) begin n_fails++; $display("FAIL wrap_issue255: got cs=%b addr=%h want cs=1 addr=ff", bus2.rom_cs, bus2.rom_addr); end
    repeat (3) @(negedge clk);  // E4
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd255, 16'hFFFF}) begin n_fails++; $display("FAIL wrap_word255: got v=%b a=%h d=%h want v=1 a=ff d=ffff", bus2.instr_valid, bus2.instr_addr, bus2.instr); end
    @(negedge clk);  // E5
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd0}) begin n_fails++; $display("FAIL wrap_issue0: got cs=%b addr=%h want cs=1 addr=00", bus2.rom_cs, bus2.rom_addr); end
    repeat (3) @(negedge clk);  // E8
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd0, 16'hFFFF}) begin n_fails++; $display("FAIL wrap_word0: got v=%b a=%h d=%h want v=1 a=00 d=ffff", bus2.instr_valid, bus2.instr_addr, bus2.instr); end
  endtask

  task automatic test_reset_in_wait();
    bus2.instr_ready = 1'b0;
    bus2.fetch_en    = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);  // E5: addr 1 buffered, addr 2 in WAIT
    n_checks++; if ({bus2.instr_valid, bus2.rom_addr} !== {1'b1, 8'd2}) begin n_fails++; $display("FAIL rw_setup: got v=%b rom_addr=%h want v=1 rom_addr=02", bus2.instr_valid, bus2.rom_addr); end
    rst = 1'b1;
    @(negedge clk);  // E6
    rst = 1'b0;
    n_checks++; if ({bus2.rom_cs, bus2.rom_oe, bus2.rom_addr, bus2.instr, bus2.instr_addr, bus2.instr_valid} !== 35'd0) begin n_fails++; $display("FAIL rw_outputs: got cs=%b oe=%b ra=%h d=%h a=%h v=%b want all zero", bus2.rom_cs, bus2.rom_oe, bus2.rom_addr, bus2.instr, bus2.instr_addr, bus2.instr_valid); end
    @(negedge clk);  // E7: late data on the bus, DUT issues addr 1 instead
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr, bus2.instr_valid} !== {1'b1, 8'd1, 1'b0}) begin n_fails++; $display("FAIL rw_reissue: got cs=%b addr=%h v=%b want cs=1 addr=01 v=0", bus2.rom_cs, bus2.rom_addr, bus2.instr_valid); end
    repeat (2) @(negedge clk);  // E9
    n_checks++; if (bus2.instr_valid !== 1'b0) begin n_fails++; $display("FAIL rw_no_late_push: got valid=%b want 0", bus2.instr_valid); end
    @(negedge clk);  // E10
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr, bus2.instr} !== {1'b1, 8'd1, 16'h007F}) begin n_fails++; $display("FAIL rw_word1: got v=%b a=%h d=%h want v=1 a=01 d=007f", bus2.instr_valid, bus2.instr_addr, bus2.instr); end
  endtask

  task automatic test_fetch_en();
    int n_cs;
    n_cs = 0;
    bus2.instr_ready = 1'b1;
    bus2.fetch_en    = 1'b1;
    do_reset();
    @(negedge clk);  // E0
    bus2.fetch_en = 1'b0;
    repeat (3) @(negedge clk);  // E3: in-flight read still completes
    n_checks++; if ({bus2.instr_valid, bus2.instr_addr} !== {1'b1, 8'd1}) begin n_fails++; $display("FAIL stall_completes: got v=%b a=%h want v=1 a=01", bus2.instr_valid, bus2.instr_addr); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.rom_cs) n_cs++;
    end
    n_checks++; if (n_cs != 0) begin n_fails++; $display("FAIL stall_no_issue: got %0d CS pulses want 0", n_cs); end
    bus2.fetch_en = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus2.rom_cs, bus2.rom_addr} !== {1'b1, 8'd2}) begin n_fails++; $display("FAIL stall_resume: got cs=%b addr=%h want cs=1 addr=02", bus2.rom_cs, bus2.rom_addr); end
  endtask

  task automatic test_latency(input int sel);
    int n, m;
    bit ok;
    logic [7:0] a;
    mon_sel = sel;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin @(negedge clk); if (m_cs) ok = 1'b1; end
      n_checks++; if (!ok) begin n_fails++; $display("FAIL lat%0d_issue_timeout: fetch %0d got no CS in 40 cycles want a CS pulse", sel, k); break; end
      n = cyc; a = m_addr;
      n_checks++; if (a !== 8'(k + 1)) begin n_fails++; $display("FAIL lat%0d_issue_addr: fetch %0d got %h want %h", sel, k, a, 8'(k + 1)); end
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin @(negedge clk); if (m_valid) ok = 1'b1; end
      n_checks++; if (!ok) begin n_fails++; $display("FAIL lat%0d_valid_timeout: fetch %0d got no instr_valid in 40 cycles want valid", sel, k); break; end
      m = cyc;
      n_checks++; if (m - n - 1 != sel) begin n_fails++; $display("FAIL lat%0d_distance: fetch %0d got %0d posedges want %0d", sel, k, m - n - 1, sel); end
      n_checks++; if ({m_iaddr, m_instr} !== {a, rom_word(a)}) begin n_fails++; $display("FAIL lat%0d_word: fetch %0d got a=%h d=%h want a=%h d=%h", sel, k, m_iaddr, m_instr, a, rom_word(a)); end
    end
  endtask

  initial begin
    bus2.instr_ready = 1'b1; bus2.fetch_en = 1'b1; bus2.jump = 1'b0; bus2.jump_addr = 8'd0;
    bus1.instr_ready = 1'b1; bus1.fetch_en = 1'b1; bus1.jump = 1'b0; bus1.jump_addr = 8'd0;
    bus7.instr_ready = 1'b1; bus7.fetch_en = 1'b1; bus7.jump = 1'b0; bus7.jump_addr = 8'd0;
    test_reset();
    test_backpressure();
    test_jump();
    test_wrap();
    test_reset_in_wait();
    test_fetch_en();
    test_latency(1);
    test_latency(7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
